// File: rtl/conv_frame_seq_pkg.sv
// Shared definitions for the convolution frame sequencer:
// GPIO command bit positions, status bit offsets and FSM encoding.
package conv_frame_seq_pkg;

    localparam int GPIO_START  = 0;
    localparam int GPIO_NEXT   = 1;
    localparam int GPIO_KI     = 2;
    localparam int GPIO_SETLEN = 3;
    localparam int GPIO_CHBLK  = 4;
    localparam int NUM_CMD     = 5;

    // status bits sit just above the data field of o_gpio
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_WRAP = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_frame_seq_if.sv
// Memory / convolver side bundle of the frame sequencer.
// master = sequencer, slave = datapath (convolver + memory control).
interface conv_frame_seq_if #(
    parameter int NB_ADDRESS = 10,
    parameter int BITS_DATA  = 11
);
    logic [NB_ADDRESS-1:0] raddr;
    logic [NB_ADDRESS-1:0] waddr;
    logic                  valid;
    logic                  wvalid;
    logic                  ki;
    logic                  sop;
    logic                  eop;
    logic                  chblk;
    logic [BITS_DATA-1:0]  data;

    modport master (
        output raddr, waddr, valid, wvalid,
        output ki, sop, eop, chblk,
        input  data
    );

    modport slave (
        input  raddr, waddr, valid, wvalid,
        input  ki, sop, eop, chblk,
        output data
    );
endinterface

// File: rtl/conv_frame_seq_sync.sv
// Two-flop synchronizer plus rising-edge detector for GPIO bits.
// A rise is flagged for one cycle, two edges after the input changes.
module gpio_edge_sync #(
    parameter int W = 5
) (
    input  logic         CLK100MHZ,
    input  logic         i_reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);
    logic [W-1:0] s1, s2, prev;

    // metastability chain followed by the previous-value register
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;
endmodule

// File: rtl/conv_frame_seq.sv
// GPIO-driven frame sequencer: read/write address streams with a
// fixed write lag, frame framing signals and processor readback.
module conv_frame_seq
    import conv_frame_seq_pkg::*;
#(
    parameter int NB_ADDRESS = 10,
    parameter int BITS_DATA  = 11,
    parameter int GPIO_D     = 32,
    parameter int LATENCY    = 3,
    parameter int LEN_RST    = 2**NB_ADDRESS-1
) (
    input  logic              CLK100MHZ,
    input  logic              i_reset,
    input  logic [GPIO_D-1:0] i_gpio,
    output logic [GPIO_D-1:0] o_gpio,
    output logic              o_led,
    conv_frame_seq_if.master  mem
);
    localparam logic [NB_ADDRESS-1:0] LEN_INIT =
        LEN_RST[NB_ADDRESS-1:0];

    logic [NUM_CMD-1:0] cmd_lvl, cmd_rise;

    gpio_edge_sync #(.W(NUM_CMD)) u_sync (
        .CLK100MHZ (CLK100MHZ),
        .i_reset   (i_reset),
        .din       (i_gpio[NUM_CMD-1:0]),
        .level     (cmd_lvl),
        .rise      (cmd_rise)
    );

    logic start_p, next_p, setlen_p, chblk_p;
    assign start_p  = cmd_rise[GPIO_START];
    assign next_p   = cmd_rise[GPIO_NEXT];
    assign setlen_p = cmd_rise[GPIO_SETLEN];
    assign chblk_p  = cmd_rise[GPIO_CHBLK];

    logic [NB_ADDRESS-1:0] payload;
    assign payload = i_gpio[GPIO_D-1 -: NB_ADDRESS];

    logic unused_bits;
    assign unused_bits = ^{cmd_lvl[4:3], cmd_lvl[1:0],
                           i_gpio[GPIO_D-NB_ADDRESS-1:NUM_CMD]};

    state_t state, state_n;

    logic [NB_ADDRESS-1:0] raddr, waddr, rd_ptr, len_last;
    logic                  valid, sop, eop, chblk, ki;
    logic                  busy, done, rd_wrap;
    logic [LATENCY-1:0]    vpipe;
    logic                  wvalid;
    logic [BITS_DATA-1:0]  data_q;
    logic                  rd_last, wr_last;

    // write-back valid is the read valid delayed by the pipe latency
    assign wvalid  = vpipe[LATENCY-1];
    assign rd_last = (raddr == len_last);
    assign wr_last = wvalid && (waddr == len_last);

    // state register
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start_p) state_n = S_RUN;
            S_RUN:   if (rd_last) state_n = S_DRAIN;
            S_DRAIN: if (wr_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // address generation, framing flags and IDLE-only commands
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            raddr    <= '0;
            waddr    <= '0;
            rd_ptr   <= '0;
            len_last <= LEN_INIT;
            valid    <= 1'b0;
            vpipe    <= '0;
            sop      <= 1'b0;
            eop      <= 1'b1;
            chblk    <= 1'b0;
            ki       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_wrap  <= 1'b0;
            data_q   <= '0;
        end else begin
            chblk    <= 1'b0;
            data_q   <= mem.data;
            vpipe[0] <= valid;
            for (int i = 1; i < LATENCY; i++)
                vpipe[i] <= vpipe[i-1];
            // hold at the last write address, never wrap
            if (wvalid && !rd_last_w())
                waddr <= waddr + 1'b1;
            unique case (state)
                S_IDLE: begin
                    ki <= cmd_lvl[GPIO_KI];
                    if (setlen_p) len_last <= payload;
                    if (chblk_p) begin
                        chblk <= 1'b1;
                        done  <= 1'b0;
                    end
                    if (start_p) begin
                        raddr   <= '0;
                        waddr   <= '0;
                        rd_ptr  <= '0;
                        valid   <= 1'b1;
                        sop     <= 1'b1;
                        eop     <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        rd_wrap <= 1'b0;
                    end else if (next_p) begin
                        raddr <= rd_ptr;
                        if (rd_ptr >= len_last) begin
                            rd_ptr  <= '0;
                            rd_wrap <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (rd_last) valid <= 1'b0;
                    else         raddr <= raddr + 1'b1;
                end
                S_DRAIN: begin
                    if (wr_last) begin
                        sop  <= 1'b0;
                        eop  <= 1'b1;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    function automatic logic rd_last_w();
        return waddr == len_last;
    endfunction

    // processor readback word
    always_comb begin
        o_gpio = '0;
        o_gpio[BITS_DATA-1:0]       = data_q;
        o_gpio[BITS_DATA + ST_BUSY] = busy;
        o_gpio[BITS_DATA + ST_DONE] = done;
        o_gpio[BITS_DATA + ST_WRAP] = rd_wrap;
    end

    assign mem.raddr  = raddr;
    assign mem.waddr  = waddr;
    assign mem.valid  = valid;
    assign mem.wvalid = wvalid;
    assign mem.ki     = ki;
    assign mem.sop    = sop;
    assign mem.eop    = eop;
    assign mem.chblk  = chblk;
    assign o_led      = eop;
endmodule

// File: tb/tb_conv_frame_seq.sv
// Directed bench for conv_frame_seq: framing, command filtering,
// readback and asynchronous reset behaviour.
module tb_conv_frame_seq;

    logic        clk;
    logic        rst;
    logic [31:0] i_gpio;
    logic [31:0] o_gpio;
    logic        o_led;
    logic        ki_lvl;
    int          total;
    int          bad;

    conv_frame_seq_if #(.NB_ADDRESS(10), .BITS_DATA(11)) mem_if ();

    conv_frame_seq dut (
        .CLK100MHZ (clk),
        .i_reset   (rst),
        .i_gpio    (i_gpio),
        .o_gpio    (o_gpio),
        .o_led     (o_led),
        .mem       (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] fdat(input logic [9:0] a);
        logic [10:0] t;
        t = {1'b0, a};
        return t * 11'd5 + 11'd3;
    endfunction

    // memory with one cycle of read latency
    always @(posedge clk) mem_if.data <= fdat(mem_if.raddr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] bits, input logic [9:0] pay);
        logic [4:0] b;
        b = bits;
        b[2] = b[2] | ki_lvl;
        i_gpio = '0;
        i_gpio[31:22] = pay;
        i_gpio[4:0] = b;
        step();
        i_gpio[4:0] = {2'b00, ki_lvl, 2'b00};
    endtask

    task automatic frame_mon(input int last, input string tag);
        int fv, fw, lw, nr, nw, rerr, werr, dcyc, serr, kerr;
        fv = -1; fw = -1; lw = -1; nr = 0; nw = 0;
        rerr = 0; werr = 0; dcyc = -1; serr = 0; kerr = 0;
        for (int c = 0; c < 3000 && dcyc < 0; c++) begin
            step();
            if (mem_if.ki !== 1'b0) kerr++;
            if (mem_if.valid) begin
                if (mem_if.raddr !== 10'(nr)) rerr++;
                if (fv < 0) fv = c;
                nr++;
            end
            if (mem_if.wvalid) begin
                if (mem_if.waddr !== 10'(nw)) werr++;
                if (fw < 0) fw = c;
                lw = c;
                nw++;
            end
            if ((mem_if.valid || mem_if.wvalid) &&
                (!mem_if.sop || !o_gpio[11] || mem_if.eop)) serr++;
            if (fv >= 0 && o_gpio[12]) begin
                dcyc = c;
                check({tag, "_eop"}, 32'(mem_if.eop), 1);
                check({tag, "_led"}, 32'(o_led), 1);
                check({tag, "_busy"}, 32'(o_gpio[11]), 0);
                check({tag, "_sop"}, 32'(mem_if.sop), 0);
                check({tag, "_wv_done"}, 32'(mem_if.wvalid), 0);
            end
        end
        check({tag, "_timeout"}, 32'(dcyc >= 0), 1);
        check({tag, "_reads"}, 32'(nr), 32'(last + 1));
        check({tag, "_writes"}, 32'(nw), 32'(last + 1));
        check({tag, "_rseq"}, 32'(rerr), 0);
        check({tag, "_wseq"}, 32'(werr), 0);
        check({tag, "_lat"}, 32'(fw - fv), 3);
        check({tag, "_done_at"}, 32'(dcyc - lw), 1);
        check({tag, "_frame_flags"}, 32'(serr), 0);
        check({tag, "_ki"}, 32'(kerr), 0);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_eop"}, 32'(mem_if.eop), 1);
        check({tag, "_led"}, 32'(o_led), 1);
        check({tag, "_raddr"}, 32'(mem_if.raddr), 0);
        check({tag, "_waddr"}, 32'(mem_if.waddr), 0);
        check({tag, "_valid"}, 32'(mem_if.valid), 0);
        check({tag, "_wvalid"}, 32'(mem_if.wvalid), 0);
        check({tag, "_sop"}, 32'(mem_if.sop), 0);
        check({tag, "_chblk"}, 32'(mem_if.chblk), 0);
        check({tag, "_ki"}, 32'(mem_if.ki), 0);
        check({tag, "_status"}, 32'(o_gpio[13:11]), 0);
        check({tag, "_len"}, 32'(dut.len_last), 1023);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rb_exp [4];
        int nvalid;
        int found;
        total = 0;
        bad = 0;
        ki_lvl = 1'b0;
        i_gpio = '0;
        rst = 1'b0;
        repeat (3) step();
        reset_vals("rst");
        check("rst_gpio", o_gpio, 0);
        rst = 1'b1;
        repeat (3) step();
        reset_vals("rel");

        // 8-word frame
        pulse(5'b01000, 10'd7);
        repeat (3) step();
        check("len7", 32'(dut.len_last), 7);
        pulse(5'b00001, 10'd7);
        frame_mon(7, "f8");

        // commands during RUN must be ignored
        repeat (3) step();
        pulse(5'b00001, 10'd7);
        fork
            frame_mon(7, "filt");
            begin
                repeat (3) step();
                pulse(5'b01101, 10'd3);
            end
        join
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mem_if.valid) nvalid++;
        end
        check("filt_no_restart", 32'(nvalid), 0);
        check("filt_len", 32'(dut.len_last), 7);

        // short frame shorter than the latency
        pulse(5'b01000, 10'd1);
        repeat (3) step();
        pulse(5'b00001, 10'd1);
        frame_mon(1, "short");

        // block change pulse clears done
        repeat (2) step();
        check("pre_chblk_done", 32'(o_gpio[12]), 1);
        pulse(5'b10000, 10'd1);
        step();
        check("chblk_idle", 32'(mem_if.chblk), 0);
        step();
        check("chblk_hi", 32'(mem_if.chblk), 1);
        check("chblk_done", 32'(o_gpio[12]), 0);
        step();
        check("chblk_one", 32'(mem_if.chblk), 0);

        // ki follows its level in IDLE
        ki_lvl = 1'b1;
        i_gpio[2] = 1'b1;
        repeat (2) step();
        check("ki_lag", 32'(mem_if.ki), 0);
        step();
        check("ki_set", 32'(mem_if.ki), 1);
        ki_lvl = 1'b0;
        i_gpio[2] = 1'b0;
        repeat (3) step();
        check("ki_clr", 32'(mem_if.ki), 0);

        // readback with wrap
        pulse(5'b01000, 10'd2);
        repeat (3) step();
        rb_exp[0] = 10'd0;
        rb_exp[1] = 10'd1;
        rb_exp[2] = 10'd2;
        rb_exp[3] = 10'd0;
        for (int i = 0; i < 4; i++) begin
            pulse(5'b00010, 10'd2);
            repeat (2) step();
            check($sformatf("rb_addr%0d", i), 32'(mem_if.raddr),
                  32'(rb_exp[i]));
            check($sformatf("rb_wrap%0d", i), 32'(o_gpio[13]),
                  32'(i >= 2));
            repeat (2) step();
            check($sformatf("rb_data%0d", i), 32'(o_gpio[10:0]),
                  32'(fdat(rb_exp[i])));
        end

        // reset in the middle of a full-length frame
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        pulse(5'b00001, 10'd0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (mem_if.valid && mem_if.raddr == 10'd5) found = 1;
        end
        check("mid_reach5", 32'(found), 1);
        rst = 1'b0;
        #1;
        reset_vals("mid");
        check("mid_busy", 32'(o_gpio[11]), 0);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        check("mid_idle_valid", 32'(mem_if.valid), 0);
        pulse(5'b00001, 10'd0);
        frame_mon(1023, "full");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
